msrh_dtlb: RTL
==============

Name: msrh_dtlb

Overview:
- Fully-associative data TLB for one LSU pipe, directly upstream of the page-table walker.
- Translates load/store virtual addresses with a one-cycle registered response.
- On a miss, issues exactly one walk request and installs the returned leaf PTE (4K/2M/1G pages, Sv39).
- Reports permission faults and walk faults to the LSU pipe, and supports a full sfence.vma flush.

Parameters:
- ENTRIES, 8, number of TLB entries (power of 2, ≥2).
- VADDR_W, 39, virtual address width.
- PADDR_W, 56, physical address width.
- PG_LEVELS, 3, page table levels; VPN field 9 bits, page offset 12 bits.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  lookup request.
- i_req_vaddr  in  VADDR_W  virtual address.
- i_req_store  in  1  1=store, 0=load.
- o_resp_valid  out  1  registered response, one cycle after the request.
- o_resp_hit  out  1  translation found.
- o_resp_paddr  out  PADDR_W  translated address; valid when hit.
- o_resp_pf  out  1  page fault, from the permission check or a completed faulting walk.
- o_ptw_req_valid  out  1  walk request.
- i_ptw_req_ready  in  1  walker accepts.
- o_ptw_req_vpn  out  27  VPN to walk.
- i_ptw_resp_valid  in  1  walk result.
- i_ptw_resp_pte  in  64  Sv39 PTE; v/r/w/x/u/a/d in bits 0-7, ppn in bits 53:10.
- i_ptw_resp_level  in  2  level of the returned PTE (0=4K, 1=2M, 2=1G).
- i_sfence_valid  in  1  flush all entries.

Behaviour:
- Reset: all entry valids 0; state IDLE; victim pointer 0; fault latch clear. All outputs 0.

Lookup
- Each entry holds: valid, vpn[26:0], level, ppn[43:0], r, w, a, d.
- Entry match: valid, and VPN bits [26:9×level] equal.
- At most one entry may match. A multi-hit is an assertion error.
- Response registered; o_resp_valid = i_req_valid delayed one cycle.
- paddr = {ppn with its low 9×level bits replaced by the corresponding vaddr VPN bits, vaddr[11:0]}.
- o_resp_pf on hit when any of:
  - a=0;
  - load and r=0;
  - store and (w=0 or d=0).
- No hardware A/D update is performed.

Miss FSM: IDLE → REQ → WAIT → IDLE
- IDLE: a miss latches the VPN and store flag, and moves to REQ on the cycle after the request. Misses arriving while not IDLE return hit=0, pf=0 and are dropped; the LSU replays them.
- REQ: o_ptw_req_valid=1 and VPN held stable until i_ptw_req_ready. Handshake completes when valid and ready are both high; then go to WAIT.
- WAIT: on i_ptw_resp_valid, return to IDLE.
  - Fill: if the PTE is a leaf (v=1 and (r|w|x)) and not bad, write the entry at the victim pointer, then increment the pointer (wrap ENTRIES-1 → 0).
  - Faulting walk: if not a leaf, or bad (v=0, or w=1 with r=0), no fill. Set the fault latch with the VPN.
- Fault latch: the next lookup whose VPN equals the latched VPN and misses returns o_resp_pf=1, then clears the latch. Any sfence also clears the latch.
- A fill becomes visible to lookups starting the following cycle. A lookup in the same cycle as the fill misses.

Flush
- i_sfence_valid clears all valids at the next edge.
- In REQ: the FSM continues normally.
- In WAIT: set a discard flag. The pending response is consumed without fill or fault, then the flag clears.
- sfence coincident with a fill: the flush wins and the entry ends invalid.
- A lookup in the sfence cycle uses the pre-flush contents.

Reset mid-walk
- Returns to IDLE immediately.
- A late i_ptw_resp_valid arriving in IDLE is ignored.

Test Plan:
- Reset, then lookup vaddr 0x0000_1234 → resp_valid=1, hit=0; next cycle ptw_req_valid=1, vpn=0x1. Hold ready=0 for 3 cycles → vpn stable; then ready=1.
- Return PTE ppn=0x80000, level=0, v/r/w/a/d=1 → entry 0 filled. Load 0x1234 → hit, paddr=0x8000_0234, pf=0.
- Fill level=1 (2M) PTE ppn=0x80200 for vaddr 0x0040_0000. Load 0x0045_6789 → hit, paddr=0x8025_6789.
- Hit on PTE with w=0: store → pf=1; load → pf=0. Separately, a walk returns v=0 → no fill; the replayed lookup to the same VPN → pf=1, and a further replay triggers a new walk.
- Fill 9 distinct 4K pages → the 9th overwrites entry 0; the first page misses and later pages hit.
- Assert sfence in WAIT, then return a valid PTE → no fill, the lookup misses and re-walks. Also, sfence coincident with a fill → entry invalid.

Source files
------------

// File: rtl/msrh_dtlb_if.sv
// LSU-side lookup, page-table-walker handshake and flush signals of the data TLB.
// The slave modport is the TLB itself; master is whatever drives it (LSU pipe + walker).
interface msrh_dtlb_if #(
   parameter int VADDR_W = 39,
   parameter int PADDR_W = 56,
   parameter int VPN_W   = 27
);
   logic               i_req_valid;
   logic [VADDR_W-1:0] i_req_vaddr;
   logic               i_req_store;
   logic               o_resp_valid;
   logic               o_resp_hit;
   logic [PADDR_W-1:0] o_resp_paddr;
   logic               o_resp_pf;
   logic               o_ptw_req_valid;
   logic               i_ptw_req_ready;
   logic [VPN_W-1:0]   o_ptw_req_vpn;
   logic               i_ptw_resp_valid;
   logic [63:0]        i_ptw_resp_pte;
   logic [1:0]         i_ptw_resp_level;
   logic               i_sfence_valid;

   modport slave (
      input  i_req_valid, i_req_vaddr, i_req_store,
      output o_resp_valid, o_resp_hit, o_resp_paddr, o_resp_pf,
      output o_ptw_req_valid, o_ptw_req_vpn,
      input  i_ptw_req_ready, i_ptw_resp_valid, i_ptw_resp_pte, i_ptw_resp_level,
      input  i_sfence_valid
   );

   modport master (
      output i_req_valid, i_req_vaddr, i_req_store,
      input  o_resp_valid, o_resp_hit, o_resp_paddr, o_resp_pf,
      input  o_ptw_req_valid, o_ptw_req_vpn,
      output i_ptw_req_ready, i_ptw_resp_valid, i_ptw_resp_pte, i_ptw_resp_level,
      output i_sfence_valid
   );
endinterface

// File: rtl/msrh_dtlb.sv
// Fully-associative Sv39 data TLB: one-cycle registered lookup, single outstanding
// page-table walk on a miss, round-robin refill, fault latch for failed walks, global flush.
module msrh_dtlb #(
   parameter int ENTRIES   = 8,
   parameter int VADDR_W   = 39,
   parameter int PADDR_W   = 56,
   parameter int PG_LEVELS = 3
) (
   input logic          i_clk,
   input logic          i_reset_n,
   msrh_dtlb_if.slave   bus
);
   localparam int VPN_W = 9 * PG_LEVELS;
   localparam int PPN_W = PADDR_W - 12;
   localparam int IDX_W = $clog2(ENTRIES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // Bits of the VPN that take part in the tag compare for a page of the given level;
   // levels beyond the root clamp to the largest page size.
   function automatic logic [VPN_W-1:0] vpn_mask(input logic [1:0] lvl);
      logic [VPN_W-1:0] m;
      m = '1;
      for (int l = 0; l < PG_LEVELS - 1; l++) begin
         if (l < int'(lvl)) m[l*9 +: 9] = '0;
      end
      return m;
   endfunction

   function automatic logic perm_fault(input logic r, input logic w, input logic a,
                                       input logic d, input logic store);
      return !a || (!store && !r) || (store && (!w || !d));
   endfunction

   logic [ENTRIES-1:0] r_ent_valid;
   logic [VPN_W-1:0]   r_ent_vpn   [ENTRIES];
   logic [1:0]         r_ent_level [ENTRIES];
   logic [PPN_W-1:0]   r_ent_ppn   [ENTRIES];
   logic [ENTRIES-1:0] r_ent_r, r_ent_w, r_ent_a, r_ent_d;

   state_t             r_state;
   logic [IDX_W-1:0]   r_victim;
   logic               r_discard;
   logic [VPN_W-1:0]   r_walk_vpn;
   logic               r_ptw_req_valid;
   logic               r_flt_valid;
   logic [VPN_W-1:0]   r_flt_vpn;

   logic               r_resp_valid_p1;
   logic               r_resp_hit_p1;
   logic [PADDR_W-1:0] r_resp_paddr_p1;
   logic               r_resp_pf_p1;

   logic [VPN_W-1:0]   w_req_vpn;
   logic [ENTRIES-1:0] w_match;
   logic [PPN_W-1:0]   w_hit_ppn;
   logic [VPN_W-1:0]   w_hit_mask;
   logic               w_hit_r, w_hit_w, w_hit_a, w_hit_d;
   logic               w_hit;
   logic [PPN_W-1:0]   w_lo_mask;
   logic [PPN_W-1:0]   w_paddr_ppn;
   logic [PADDR_W-1:0] w_paddr;
   logic               w_perm_pf;
   logic               w_miss;
   logic               w_flt_hit;
   logic               w_start_walk;
   logic               w_pte_v, w_pte_r, w_pte_w, w_pte_x, w_pte_a, w_pte_d;
   logic               w_pte_ok;
   logic               w_resp_take;
   logic               w_fill;
   logic               w_walk_fault;
   logic               w_unused_pte;

   // ---- stage p0: associative lookup against current contents ----
   assign w_req_vpn = bus.i_req_vaddr[12 +: VPN_W];

   always_comb begin
      w_match    = '0;
      w_hit_ppn  = '0;
      w_hit_mask = '0;
      w_hit_r    = 1'b0;
      w_hit_w    = 1'b0;
      w_hit_a    = 1'b0;
      w_hit_d    = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         w_match[i] = r_ent_valid[i] &&
                      (((w_req_vpn ^ r_ent_vpn[i]) & vpn_mask(r_ent_level[i])) == '0);
         if (w_match[i]) begin
            w_hit_ppn  = w_hit_ppn  | r_ent_ppn[i];
            w_hit_mask = w_hit_mask | vpn_mask(r_ent_level[i]);
            w_hit_r    = w_hit_r | r_ent_r[i];
            w_hit_w    = w_hit_w | r_ent_w[i];
            w_hit_a    = w_hit_a | r_ent_a[i];
            w_hit_d    = w_hit_d | r_ent_d[i];
         end
      end
   end

   assign w_hit       = |w_match;
   // Superpage: the low PPN bits come straight from the virtual page number.
   assign w_lo_mask   = {{(PPN_W-VPN_W){1'b0}}, ~w_hit_mask};
   assign w_paddr_ppn = (w_hit_ppn & ~w_lo_mask) |
                        ({{(PPN_W-VPN_W){1'b0}}, w_req_vpn} & w_lo_mask);
   assign w_paddr     = {w_paddr_ppn, bus.i_req_vaddr[11:0]};
   assign w_perm_pf   = perm_fault(w_hit_r, w_hit_w, w_hit_a, w_hit_d, bus.i_req_store);

   assign w_miss       = bus.i_req_valid && !w_hit;
   assign w_flt_hit    = w_miss && r_flt_valid && (r_flt_vpn == w_req_vpn);
   assign w_start_walk = w_miss && !w_flt_hit && (r_state == S_IDLE);

   assign w_pte_v  = bus.i_ptw_resp_pte[0];
   assign w_pte_r  = bus.i_ptw_resp_pte[1];
   assign w_pte_w  = bus.i_ptw_resp_pte[2];
   assign w_pte_x  = bus.i_ptw_resp_pte[3];
   assign w_pte_a  = bus.i_ptw_resp_pte[6];
   assign w_pte_d  = bus.i_ptw_resp_pte[7];
   assign w_pte_ok = w_pte_v && (w_pte_r || w_pte_w || w_pte_x) && !(w_pte_w && !w_pte_r);
   assign w_unused_pte = &{1'b0, bus.i_ptw_resp_pte[63:54], bus.i_ptw_resp_pte[9:8],
                           bus.i_ptw_resp_pte[5:4]};

   assign w_resp_take  = (r_state == S_WAIT) && bus.i_ptw_resp_valid;
   assign w_fill       = w_resp_take && !r_discard && w_pte_ok;
   assign w_walk_fault = w_resp_take && !r_discard && !w_pte_ok;

   // ---- stage p1: registered response, walk FSM, fault latch ----
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_resp_valid_p1 <= 1'b0;
         r_resp_hit_p1   <= 1'b0;
         r_resp_paddr_p1 <= '0;
         r_resp_pf_p1    <= 1'b0;
         r_state         <= S_IDLE;
         r_victim        <= '0;
         r_discard       <= 1'b0;
         r_walk_vpn      <= '0;
         r_ptw_req_valid <= 1'b0;
         r_flt_valid     <= 1'b0;
         r_flt_vpn       <= '0;
      end else begin
         r_resp_valid_p1 <= bus.i_req_valid;
         r_resp_hit_p1   <= bus.i_req_valid && w_hit;
         r_resp_paddr_p1 <= (bus.i_req_valid && w_hit) ? w_paddr : '0;
         r_resp_pf_p1    <= (bus.i_req_valid && w_hit) ? w_perm_pf : w_flt_hit;

         case (r_state)
            S_IDLE: begin
               if (w_start_walk) begin
                  r_state         <= S_REQ;
                  r_ptw_req_valid <= 1'b1;
                  r_walk_vpn      <= w_req_vpn;
               end
            end
            S_REQ: begin
               if (bus.i_ptw_req_ready) begin
                  r_state         <= S_WAIT;
                  r_ptw_req_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (bus.i_ptw_resp_valid) begin
                  r_state   <= S_IDLE;
                  r_discard <= 1'b0;
                  if (w_fill) r_victim <= r_victim + 1'b1;
               end else if (bus.i_sfence_valid) begin
                  r_discard <= 1'b1;
               end
            end
            default: begin
               r_state         <= S_IDLE;
               r_ptw_req_valid <= 1'b0;
            end
         endcase

         if (bus.i_sfence_valid) begin
            r_flt_valid <= 1'b0;
         end else if (w_walk_fault) begin
            r_flt_valid <= 1'b1;
            r_flt_vpn   <= r_walk_vpn;
         end else if (w_flt_hit) begin
            r_flt_valid <= 1'b0;
         end
      end
   end

   // Flush is applied after the fill so a coincident sfence leaves the entry invalid.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_ent_valid <= '0;
      end else begin
         if (w_fill) r_ent_valid[r_victim] <= 1'b1;
         if (bus.i_sfence_valid) r_ent_valid <= '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_fill) begin
         r_ent_vpn[r_victim]   <= r_walk_vpn;
         r_ent_level[r_victim] <= bus.i_ptw_resp_level;
         r_ent_ppn[r_victim]   <= bus.i_ptw_resp_pte[10 +: PPN_W];
         r_ent_r[r_victim]     <= w_pte_r;
         r_ent_w[r_victim]     <= w_pte_w;
         r_ent_a[r_victim]     <= w_pte_a;
         r_ent_d[r_victim]     <= w_pte_d;
      end
   end

   always @(posedge i_clk) begin
      if (i_reset_n && bus.i_req_valid) begin
         a_multi_hit: assert ($onehot0(w_match));
      end
   end

   assign bus.o_resp_valid    = r_resp_valid_p1;
   assign bus.o_resp_hit      = r_resp_hit_p1;
   assign bus.o_resp_paddr    = r_resp_paddr_p1;
   assign bus.o_resp_pf       = r_resp_pf_p1;
   assign bus.o_ptw_req_valid = r_ptw_req_valid;
   assign bus.o_ptw_req_vpn   = r_walk_vpn;
endmodule
